instruction_loader: RTL and testbench

- Upstream feeder for the 8-bit computer's instruction memory.
- Receives a framed byte stream over a valid/ready handshake and assembles 15-bit instruction words (7-bit opcode + 8-bit literal).
- Writes each word into the instruction memory write port at consecutive addresses from 0, and holds the CPU while loading.
- Verifies an XOR checksum, then releases the CPU with a one-cycle restart pulse so PC begins at 0.

---
 rtl/instruction_loader_pkg.sv | 30 +++
 rtl/instruction_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_instruction_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// ----------------------------------------------------------------------------
// instruction_loader_pkg
//   Shared definitions for the instruction loader: default field widths of the
//   15-bit instruction word, the loader state encoding, and a small helper that
//   says which states accept stream bytes.
// ----------------------------------------------------------------------------
package instruction_loader_pkg;

  localparam int ADDR_W   = 8;                  // instruction memory / PC width
  localparam int OPCODE_W = 7;                  // instruction bits 14:8
  localparam int LIT_W    = 8;                  // instruction bits 7:0
  localparam int INSTR_W  = OPCODE_W + LIT_W;   // full instruction word

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    LOW,
    HIGH,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_e;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_bytes(input state_e s);
    return (s == COUNT) || (s == LOW) || (s == HIGH) || (s == CSUM);
  endfunction

endpackage : instruction_loader_pkg

// File: rtl/instruction_loader.sv
// ----------------------------------------------------------------------------
// instruction_loader
//   Receives a framed byte stream (COUNT, N x {LOW literal, HIGH opcode}, CSUM)
//   over valid/ready, assembles {opcode, literal} words and writes them to the
//   instruction memory at consecutive addresses from 0. The CPU is held for
//   the whole frame; a matching XOR checksum releases it with a one-cycle
//   restart pulse, anything else leaves it held with err set.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        begin a frame (honoured in IDLE, DONE, ERR only)
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     byte accepted on this edge when in_valid is also high
//   im_we        instruction memory write strobe
//   im_addr      instruction memory write address
//   im_wdata     instruction memory write word {opcode, literal}
//   cpu_hold     freezes the CPU while high
//   cpu_restart  one-cycle pulse forcing PC to 0
//   busy         frame in progress
//   done         last frame loaded with a good checksum (sticky)
//   err          last frame failed (sticky)
//   words_loaded words written in the current or last frame
// ----------------------------------------------------------------------------
module instruction_loader #(
  parameter int ADDR_W   = instruction_loader_pkg::ADDR_W,
  parameter int OPCODE_W = instruction_loader_pkg::OPCODE_W,
  parameter int LIT_W    = instruction_loader_pkg::LIT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         im_we,
  output logic [ADDR_W-1:0]            im_addr,
  output logic [OPCODE_W+LIT_W-1:0]    im_wdata,
  output logic                         cpu_hold,
  output logic                         cpu_restart,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [ADDR_W:0]              words_loaded
);

  import instruction_loader_pkg::*;

  localparam int WORD_W = OPCODE_W + LIT_W;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_e                state_q,        state_d;
  logic                  in_ready_q,     in_ready_d;
  logic                  im_we_q,        im_we_d;
  logic [ADDR_W-1:0]     im_addr_q,      im_addr_d;
  logic [WORD_W-1:0]     im_wdata_q,     im_wdata_d;
  logic                  cpu_hold_q,     cpu_hold_d;
  logic                  cpu_restart_q,  cpu_restart_d;
  logic                  busy_q,         busy_d;
  logic                  done_q,         done_d;
  logic                  err_q,          err_d;
  logic [ADDR_W:0]       words_q,        words_d;

  // Frame bookkeeping
  logic [7:0]            count_q,        count_d;   // raw N byte, 0 = 256
  logic [LIT_W-1:0]      lit_q,          lit_d;     // literal awaiting its opcode
  logic [7:0]            csum_q,         csum_d;    // running XOR of accepted bytes

  logic                  xfer;
  logic [ADDR_W:0]       n_eff;
  logic [ADDR_W:0]       words_next;

  assign xfer       = in_valid && in_ready_q;
  assign n_eff      = (count_q == 8'd0) ? (ADDR_W+1)'(256) : (ADDR_W+1)'(count_q);
  assign words_next = words_q + (ADDR_W+1)'(1);

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer latches.
    state_d       = state_q;
    im_we_d       = 1'b0;          // strobe, only high for the WRITE cycle
    im_addr_d     = im_addr_q;
    im_wdata_d    = im_wdata_q;
    cpu_hold_d    = cpu_hold_q;
    cpu_restart_d = 1'b0;          // pulse, only high on DONE entry
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    words_d       = words_q;
    count_d       = count_q;
    lit_d         = lit_q;
    csum_d        = csum_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        // The restart pulse occupies the first DONE cycle with hold still
        // high; hold drops on the following edge. ERR keeps the CPU held.
        if (state_q == DONE) begin
          cpu_hold_d = 1'b0;
        end
        if (start) begin
          state_d    = COUNT;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = '0;
          im_addr_d  = '0;
          csum_d     = 8'd0;
        end
      end

      COUNT: begin
        if (xfer) begin
          count_d = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = LOW;
        end
      end

      LOW: begin
        if (xfer) begin
          lit_d   = in_data[LIT_W-1:0];
          csum_d  = csum_q ^ in_data;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (xfer) begin
          if (in_data[7]) begin
            // Opcode bytes are 7-bit; a set MSB marks a corrupt stream.
            state_d = ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            csum_d     = csum_q ^ in_data;
            im_we_d    = 1'b1;
            im_wdata_d = {in_data[OPCODE_W-1:0], lit_q};
            state_d    = WRITE;
          end
        end
      end

      WRITE: begin
        // Address wraps to 0 after word 256; harmless since CSUM follows.
        im_addr_d = im_addr_q + ADDR_W'(1);
        words_d   = words_next;
        state_d   = (words_next < n_eff) ? LOW : CSUM;
      end

      CSUM: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (in_data == csum_q) begin
            state_d       = DONE;
            done_d        = 1'b1;
            cpu_restart_d = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is a registered decode of the state being entered, so it lines
    // up with state_q on the next cycle and never depends on in_valid.
    in_ready_d = accepts_bytes(state_d);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      im_we_q       <= 1'b0;
      im_addr_q     <= '0;
      im_wdata_q    <= '0;
      cpu_hold_q    <= 1'b0;
      cpu_restart_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      words_q       <= '0;
      count_q       <= 8'd0;
      lit_q         <= '0;
      csum_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      im_we_q       <= im_we_d;
      im_addr_q     <= im_addr_d;
      im_wdata_q    <= im_wdata_d;
      cpu_hold_q    <= cpu_hold_d;
      cpu_restart_q <= cpu_restart_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      words_q       <= words_d;
      count_q       <= count_d;
      lit_q         <= lit_d;
      csum_q        <= csum_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready     = in_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign cpu_restart  = cpu_restart_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule : instruction_loader

// File: tb/tb_instruction_loader.sv
// ----------------------------------------------------------------------------
// tb_instruction_loader
//   Drives framed byte streams into instruction_loader and checks the memory
//   writes against a scoreboard filled from the bytes being sent, plus the
//   done/err/hold/restart behaviour at the end of each frame and on reset.
// ----------------------------------------------------------------------------
module tb_instruction_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [14:0] im_wdata;
  logic        cpu_hold;
  logic        cpu_restart;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  instruction_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .cpu_restart  (cpu_restart),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [14:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];

  int n_checks    = 0;
  int n_errors    = 0;
  int we_cnt      = 0;
  int restart_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write, and the
  // loader must not be taking bytes while it writes.
  always @(negedge clk) begin
    if (rst && im_we) begin
      we_cnt++;
      check("ready_in_write", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'(im_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(im_addr), 32'(e.addr));
        check("wr_data", 32'(im_wdata), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && cpu_restart) begin
      restart_cnt++;
      check("hold_during_restart", 32'(cpu_hold), 32'd1);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_im_we"},    32'(im_we),        32'd0);
    check({tag, "_im_addr"},  32'(im_addr),      32'd0);
    check({tag, "_im_wdata"}, 32'(im_wdata),     32'd0);
    check({tag, "_in_ready"}, 32'(in_ready),     32'd0);
    check({tag, "_hold"},     32'(cpu_hold),     32'd0);
    check({tag, "_restart"},  32'(cpu_restart),  32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_done"},     32'(done),         32'd0);
    check({tag, "_err"},      32'(err),          32'd0);
    check({tag, "_words"},    32'(words_loaded), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int budget;
    int gap;
    if (stall) begin
      gap      = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (gap) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Sends frame_q after a start pulse. The first byte is already presented
  // together with start to show it is not consumed in IDLE. Expected writes
  // are derived from the frame bytes themselves.
  task automatic run_frame(input bit stall, input bit poke_start);
    int         n_eff;
    int         addr;
    int         last;
    logic [7:0] lit;
    logic [7:0] b;
    n_eff = (frame_q[0] == 8'd0) ? 256 : int'(frame_q[0]);
    addr  = 0;
    lit   = 8'd0;
    last  = 2 * n_eff;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = frame_q[0];
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < frame_q.size(); i++) begin
      b = frame_q[i];
      if (i >= 1 && i <= last) begin
        if (i % 2 == 1) begin
          lit = b;
        end else if (!b[7]) begin
          exp_q.push_back('{addr: 8'(addr), data: {b[6:0], lit}});
          addr++;
        end
      end
      if (poke_start && i == 3) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(b, stall);
    end
  endtask

  task automatic expect_done(input string tag, input int words, input int restarts_before);
    check({tag, "_done"},    32'(done),         32'd1);
    check({tag, "_err"},     32'(err),          32'd0);
    check({tag, "_busy"},    32'(busy),         32'd0);
    check({tag, "_restart"}, 32'(cpu_restart),  32'd1);
    check({tag, "_hold"},    32'(cpu_hold),     32'd1);
    check({tag, "_words"},   32'(words_loaded), 32'(words));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_restart_end"}, 32'(cpu_restart), 32'd0);
    check({tag, "_hold_drop"},   32'(cpu_hold),    32'd0);
    check({tag, "_restart_cnt"}, 32'(restart_cnt), 32'(restarts_before + 1));
  endtask

  task automatic expect_err(input string tag, input int words, input int restarts_before);
    check({tag, "_err"},     32'(err),          32'd1);
    check({tag, "_done"},    32'(done),         32'd0);
    check({tag, "_busy"},    32'(busy),         32'd0);
    check({tag, "_ready"},   32'(in_ready),     32'd0);
    check({tag, "_words"},   32'(words_loaded), 32'(words));
    repeat (3) @(negedge clk);
    check({tag, "_hold"},        32'(cpu_hold),    32'd1);
    check({tag, "_restart_cnt"}, 32'(restart_cnt), 32'(restarts_before));
    check({tag, "_pending"},     32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_normal(input logic [7:0] csum);
    frame_q = {8'h02, 8'h05, 8'h01, 8'hFF, 8'h7F, csum};
  endtask

  initial begin
    int         rs;
    int         we_before;
    logic [7:0] x;

    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Normal load
    rs = restart_cnt;
    load_normal(8'h86);
    run_frame(1'b0, 1'b0);
    expect_done("normal", 2, rs);

    // Bad checksum
    rs = restart_cnt;
    load_normal(8'h87);
    run_frame(1'b0, 1'b0);
    expect_err("badcsum", 2, rs);

    // Illegal opcode byte
    rs        = restart_cnt;
    we_before = we_cnt;
    frame_q   = {8'h01, 8'h10, 8'h80};
    run_frame(1'b0, 1'b0);
    expect_err("illegal", 0, rs);
    check("illegal_no_we", 32'(we_cnt), 32'(we_before));

    // Stalls between bytes, plus a start pulse mid-frame that must be ignored
    rs = restart_cnt;
    load_normal(8'h86);
    run_frame(1'b1, 1'b1);
    expect_done("stall", 2, rs);

    // N = 0: 256 words, literal = address, opcode 0
    rs = restart_cnt;
    frame_q.delete();
    frame_q.push_back(8'h00);
    x = 8'h00;
    for (int a = 0; a < 256; a++) begin
      frame_q.push_back(8'(a));
      frame_q.push_back(8'h00);
      x = x ^ 8'(a);
    end
    frame_q.push_back(x);
    run_frame(1'b0, 1'b0);
    expect_done("n256", 256, rs);

    // Reset after the first word is written
    we_before = we_cnt;
    frame_q   = {8'h02, 8'h05, 8'h01};
    run_frame(1'b0, 1'b0);
    #1;
    check("midrst_first_write", 32'(we_cnt), 32'(we_before + 1));
    check("midrst_hold_before", 32'(cpu_hold), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    rs = restart_cnt;
    load_normal(8'h86);
    run_frame(1'b1, 1'b0);
    expect_done("after_rst", 2, rs);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_instruction_loader
